// File: rtl/mlp_layer_sequencer.sv
// Control FSM for one fully connected MLP layer driving a chunked dot-product accumulator.
// Optional build macro MLP_SEQ_RELU_EN clamps negative neuron results to zero at WRITE capture.
module mlp_layer_sequencer #(
  parameter int SIZE        = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_NEURONS = 10,
  parameter int NUM_CHUNKS  = 4,
  localparam int NW = (NUM_NEURONS > 2) ? $clog2(NUM_NEURONS) : 1,
  localparam int CW = (NUM_CHUNKS > 2) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         dot_reset,
  output logic                         dot_run,
  output logic                         bias_en,
  input  logic                         dot_finished,
  input  logic signed [DATA_WIDTH-1:0] dot_result,
  output logic        [NW-1:0]         neuron_idx,
  output logic        [CW-1:0]         chunk_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [NW-1:0]         out_addr,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  if ((SIZE < 1) || (NUM_NEURONS < 1) || (NUM_CHUNKS < 1)) begin : g_param_err
    $error("mlp_layer_sequencer: SIZE, NUM_NEURONS and NUM_CHUNKS must all be >= 1");
  end

  localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);
  localparam logic [CW-1:0] LAST_C = CW'(NUM_CHUNKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e                         state_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           dot_reset_q;
  logic                           dot_run_q;
  logic                           bias_en_q;
  logic                           out_valid_q;
  logic        [NW-1:0]           neuron_q;
  logic        [CW-1:0]           chunk_q;
  logic signed [DATA_WIDTH-1:0]   out_data_q;
  logic signed [DATA_WIDTH-1:0]   capture_d;

  // Activation applied to the accumulated neuron value at the moment it is latched for writing.
  function automatic logic signed [DATA_WIDTH-1:0] shape_result(
    input logic signed [DATA_WIDTH-1:0] v
  );
`ifdef MLP_SEQ_RELU_EN
    if (v[DATA_WIDTH-1] == 1'b1) begin
      return {DATA_WIDTH{1'b0}};
    end else begin
      return v;
    end
`else
    return v;
`endif
  endfunction

  // Value to latch into out_data on the DRAIN->WRITE transition.
  always_comb begin
    capture_d = shape_result(dot_result);
  end

  // Layer sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dot_reset_q <= 1'b0;
      dot_run_q   <= 1'b0;
      bias_en_q   <= 1'b1;
      out_valid_q <= 1'b0;
      neuron_q    <= {NW{1'b0}};
      chunk_q     <= {CW{1'b0}};
      out_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      done_q      <= 1'b0;
      dot_reset_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_CLEAR;
            busy_q      <= 1'b1;
            dot_reset_q <= 1'b1;
            neuron_q    <= {NW{1'b0}};
            chunk_q     <= {CW{1'b0}};
            bias_en_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          state_q   <= S_RUN;
          dot_run_q <= 1'b1;
        end
        S_RUN: begin
          if (dot_finished) begin
            state_q   <= S_DRAIN;
            dot_run_q <= 1'b0;
          end else begin
            state_q <= S_RUN;
          end
        end
        // Waiting for finished to fall guarantees the accumulator sees a fresh rising edge per chunk.
        S_DRAIN: begin
          if (!dot_finished) begin
            if (chunk_q < LAST_C) begin
              state_q   <= S_RUN;
              chunk_q   <= chunk_q + CW'(1);
              bias_en_q <= 1'b0;
              dot_run_q <= 1'b1;
            end else begin
              state_q     <= S_WRITE;
              out_valid_q <= 1'b1;
              out_data_q  <= capture_d;
            end
          end else begin
            state_q <= S_DRAIN;
          end
        end
        S_WRITE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (neuron_q < LAST_N) begin
              state_q     <= S_CLEAR;
              neuron_q    <= neuron_q + NW'(1);
              chunk_q     <= {CW{1'b0}};
              bias_en_q   <= 1'b1;
              dot_reset_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= S_WRITE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          dot_run_q   <= 1'b0;
          bias_en_q   <= 1'b1;
          out_valid_q <= 1'b0;
          neuron_q    <= {NW{1'b0}};
          chunk_q     <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dot_reset  = dot_reset_q;
  assign dot_run    = dot_run_q;
  assign bias_en    = bias_en_q;
  assign neuron_idx = neuron_q;
  assign chunk_idx  = chunk_q;
  assign out_valid  = out_valid_q;
  assign out_addr   = neuron_q;
  assign out_data   = out_data_q;

endmodule
